// File: rtl/control_input_conditioner.sv
// Front-panel control conditioner: synchronises and debounces raw KEYs and switches,
// derives press / auto-repeat strobes and the slow control tick and clock.
module control_input_conditioner #(
  parameter int unsigned DB_CYCLES    = 500000,
  parameter int unsigned TICK_DIV     = 537634,
  parameter int unsigned REPEAT_DELAY = 40,
  parameter int unsigned REPEAT_RATE  = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [3:0] key_n,
  input  logic [9:0] sw,
  output logic [3:0] key_n_clean,
  output logic [9:0] sw_clean,
  output logic [3:0] key_press,
  output logic [3:0] key_repeat,
  output logic       button_tick,
  output logic       button_clock
);

  localparam int unsigned NK      = 4;
  localparam int unsigned SC_W    = $clog2(DB_CYCLES);
  localparam int unsigned TC_W    = $clog2(TICK_DIV);
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CNT_W   = $clog2(RPT_MAX + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic [3:0]      key_s1, key_s2;
  logic [9:0]      sw_s1, sw_s2;
  logic [SC_W-1:0] sc;
  logic            sample_stb;
  logic [3:0]      key_h1, key_h0;
  logic [9:0]      sw_h1, sw_h0;
  logic [3:0]      key_agree;
  logic [9:0]      sw_agree;
  logic [TC_W-1:0] tc;
  logic [3:0]      key_prev;
  logic [3:0]      press_det;

  logic [1:0]       state     [NK];
  logic [1:0]       state_d   [NK];
  logic [CNT_W-1:0] cnt       [NK];
  logic [CNT_W-1:0] cnt_d     [NK];
  logic [CNT_W-1:0] cnt_inc   [NK];
  logic [3:0]       repeat_d;

  // Two-flop synchronisers; keys idle high, switches idle low
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key_s1 <= '1;
      key_s2 <= '1;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
    end
  end

  assign sample_stb = (sc == SC_W'(DB_CYCLES - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)         sc <= '0;
    else if (sample_stb) sc <= '0;
    else                 sc <= sc + SC_W'(1);
  end

  // A level is accepted only when the two previous samples agree with the current one
  assign key_agree = ~(key_h1 ^ key_h0) & ~(key_h0 ^ key_s2);
  assign sw_agree  = ~(sw_h1 ^ sw_h0) & ~(sw_h0 ^ sw_s2);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key_h1      <= '1;
      key_h0      <= '1;
      key_n_clean <= '1;
      sw_h1       <= '0;
      sw_h0       <= '0;
      sw_clean    <= '0;
    end else if (sample_stb) begin
      key_n_clean <= (key_agree & key_s2) | (~key_agree & key_n_clean);
      key_h1      <= key_h0;
      key_h0      <= key_s2;
      sw_clean    <= (sw_agree & sw_s2) | (~sw_agree & sw_clean);
      sw_h1       <= sw_h0;
      sw_h0       <= sw_s2;
    end
  end

  // Control tick divider
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tc           <= '0;
      button_tick  <= 1'b0;
      button_clock <= 1'b1;
    end else begin
      tc           <= (tc == TC_W'(TICK_DIV - 1)) ? '0 : tc + TC_W'(1);
      button_tick  <= (tc == TC_W'(TICK_DIV - 1));
      button_clock <= (tc < TC_W'(TICK_DIV / 2));
    end
  end

  assign press_det = key_prev & ~key_n_clean;

  always_comb begin
    for (int i = 0; i < int'(NK); i++) begin
      cnt_inc[i] = cnt[i] + CNT_W'(1);
    end
  end

  // Per-key auto-repeat next state; a released key always falls back to idle silently
  always_comb begin
    repeat_d = '0;
    for (int i = 0; i < int'(NK); i++) begin
      state_d[i] = state[i];
      cnt_d[i]   = cnt[i];
    end
    for (int i = 0; i < int'(NK); i++) begin
      if (key_n_clean[i]) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
      end else begin
        case (state[i])
          ST_IDLE: begin
            if (press_det[i]) begin
              repeat_d[i] = 1'b1;
              state_d[i]  = ST_DELAY;
              cnt_d[i]    = '0;
            end
          end
          ST_DELAY: begin
            if (button_tick) begin
              if (cnt_inc[i] == CNT_W'(REPEAT_DELAY)) begin
                repeat_d[i] = 1'b1;
                state_d[i]  = ST_REPEAT;
                cnt_d[i]    = '0;
              end else begin
                cnt_d[i] = cnt_inc[i];
              end
            end
          end
          ST_REPEAT: begin
            if (button_tick) begin
              if (cnt_inc[i] == CNT_W'(REPEAT_RATE)) begin
                repeat_d[i] = 1'b1;
                cnt_d[i]    = '0;
              end else begin
                cnt_d[i] = cnt_inc[i];
              end
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key_prev   <= '1;
      key_press  <= '0;
      key_repeat <= '0;
      for (int i = 0; i < int'(NK); i++) begin
        state[i] <= ST_IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      key_prev   <= key_n_clean;
      key_press  <= press_det;
      key_repeat <= repeat_d;
      for (int i = 0; i < int'(NK); i++) begin
        state[i] <= state_d[i];
        cnt[i]   <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_control_input_conditioner.sv
// Directed bench for control_input_conditioner with short debounce / tick periods.
module tb_control_input_conditioner;

  localparam int unsigned DB = 4;
  localparam int unsigned TD = 10;
  localparam int unsigned RD = 3;
  localparam int unsigned RR = 2;

  logic       clock = 1'b0;
  logic       resetn;
  logic [3:0] key_n;
  logic [9:0] sw;
  logic [3:0] key_n_clean;
  logic [9:0] sw_clean;
  logic [3:0] key_press;
  logic [3:0] key_repeat;
  logic       button_tick;
  logic       button_clock;

  always #5 clock = ~clock;

  control_input_conditioner #(
    .DB_CYCLES(DB), .TICK_DIV(TD), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clock(clock), .resetn(resetn), .key_n(key_n), .sw(sw),
    .key_n_clean(key_n_clean), .sw_clean(sw_clean), .key_press(key_press),
    .key_repeat(key_repeat), .button_tick(button_tick), .button_clock(button_clock)
  );

  typedef struct {
    logic [3:0] key;
    logic [9:0] sw;
    int         hold;
    logic [3:0] exp_key;
    logic [9:0] exp_sw;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int k = 0;
  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Each step ends 3 ns after a rising edge, away from both clock edges
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      k++;
    end
    #3;
  endtask

  // Monitor of the key under test: press/fall counts and tick count at each repeat pulse
  int mk = 0;
  int tcount = 0;
  int rep_log [64];
  int rep_n = 0;
  int press_cnt = 0;
  int fall_cnt = 0;
  int rel_rep = 0;
  logic [3:0] prev_clean = 4'hF;

  always @(negedge clock) begin
    prev_clean <= key_n_clean;
    if (resetn) begin
      if (key_repeat[mk] && rep_n < 64) begin
        rep_log[rep_n] <= key_press[mk] ? 0 : tcount;
        rep_n <= rep_n + 1;
      end
      tcount <= key_press[mk] ? int'(button_tick) : tcount + int'(button_tick);
      if (key_press[mk]) press_cnt <= press_cnt + 1;
      if (prev_clean[mk] && !key_n_clean[mk]) fall_cnt <= fall_cnt + 1;
      if (key_repeat[mk] && key_n_clean[mk]) rel_rep <= rel_rep + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key_clean"}, 32'(key_n_clean), 32'h0000000F);
    check({tag, "_sw_clean"},  32'(sw_clean),    32'h0);
    check({tag, "_press"},     32'(key_press),   32'h0);
    check({tag, "_repeat"},    32'(key_repeat),  32'h0);
    check({tag, "_tick"},      32'(button_tick), 32'h0);
    check({tag, "_bclock"},    32'(button_clock), 32'h1);
  endtask

  initial begin
    int lat, n, q0, p0, f0, r0;

    tbl[0]  = '{4'hF, 10'h000, 20, 4'hF, 10'h000};
    tbl[1]  = '{4'hF, 10'h3FF, 20, 4'hF, 10'h3FF};
    tbl[2]  = '{4'hF, 10'h000,  6, 4'hF, 10'h3FF};
    tbl[3]  = '{4'hF, 10'h3FF, 20, 4'hF, 10'h3FF};
    tbl[4]  = '{4'hA, 10'h155, 20, 4'hA, 10'h155};
    tbl[5]  = '{4'hF, 10'h000, 20, 4'hF, 10'h000};
    tbl[6]  = '{4'hF, 10'h020,  6, 4'hF, 10'h000};
    tbl[7]  = '{4'hF, 10'h000, 20, 4'hF, 10'h000};
    tbl[8]  = '{4'hF, 10'h020, 20, 4'hF, 10'h020};
    tbl[9]  = '{4'h0, 10'h020,  6, 4'hF, 10'h020};
    tbl[10] = '{4'hF, 10'h020, 20, 4'hF, 10'h020};

    resetn = 1'b0;
    key_n  = 4'hF;
    sw     = 10'h000;
    step(3);
    check_reset_outputs("por");
    resetn = 1'b1;
    k = 0;

    // Debounce levels and glitch rejection
    for (int i = 0; i < 11; i++) begin
      key_n = tbl[i].key;
      sw    = tbl[i].sw;
      step(tbl[i].hold);
      check($sformatf("vec%0d_key", i), 32'(key_n_clean), 32'(tbl[i].exp_key));
      check($sformatf("vec%0d_sw", i),  32'(sw_clean),    32'(tbl[i].exp_sw));
    end

    // Reset asserted mid-cycle takes effect before the next edge
    resetn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    step(2);
    resetn = 1'b1;
    k = 0;
    check("tick_k0", 32'(button_tick), 32'h0);
    check("bclk_k0", 32'(button_clock), 32'h1);
    for (int j = 1; j <= 35; j++) begin
      step(1);
      check($sformatf("tick_k%0d", j), 32'(button_tick), (j % 10 == 0) ? 32'h1 : 32'h0);
      check($sformatf("bclk_k%0d", j), 32'(button_clock), ((j - 1) % 10 < 5) ? 32'h1 : 32'h0);
    end

    // Bouncing key 0
    mk = 0;
    step(1);
    p0 = press_cnt;
    f0 = fall_cnt;
    for (int t = 0; t < 10; t++) begin
      key_n[0] = ~key_n[0];
      step(3);
    end
    key_n[0] = 1'b0;
    lat = 0;
    while (lat < 40 && key_n_clean[0]) begin
      step(1);
      lat++;
    end
    check("bounce_fell", 32'(key_n_clean[0]), 32'h0);
    check("bounce_latency_le14", (lat <= 14) ? 32'h1 : 32'h0, 32'h1);
    step(5);
    check("bounce_falls", 32'(fall_cnt - f0), 32'h1);
    check("bounce_presses", 32'(press_cnt - p0), 32'h1);
    key_n[0] = 1'b1;
    step(20);

    // Auto-repeat on key 1: press, 3rd tick, then every 2nd tick
    mk = 1;
    step(1);
    q0 = rep_n;
    key_n[1] = 1'b0;
    step(120);
    n = rep_n - q0;
    check("rpt_count_ge4", (n >= 4) ? 32'h1 : 32'h0, 32'h1);
    for (int i = 0; i < n && i < 6; i++) begin
      check($sformatf("rpt%0d_ticks", i), 32'(rep_log[q0 + i]), (i == 0) ? 32'h0 : 32'(3 + 2 * (i - 1)));
    end
    r0 = rel_rep;
    key_n[1] = 1'b1;
    step(40);
    check("rpt_released", 32'(key_n_clean[1]), 32'h1);
    check("rpt_after_release", 32'(rel_rep - r0), 32'h0);

    // Key 2 released so its clean rise meets the repeat-due tick at edge 80
    resetn = 1'b0;
    step(2);
    resetn = 1'b1;
    k = 0;
    mk = 2;
    q0 = rep_n;
    r0 = rel_rep;
    step(1);
    key_n[2] = 1'b0;
    step(68);
    check("sim_held_k69", 32'(key_n_clean[2]), 32'h0);
    key_n[2] = 1'b1;
    step(11);
    check("sim_rise_k80", 32'(key_n_clean[2]), 32'h1);
    check("sim_tick_k80", 32'(button_tick), 32'h1);
    check("sim_pulses_before", 32'(rep_n - q0), 32'h3);
    check("sim_p0", 32'(rep_log[q0]), 32'h0);
    check("sim_p1", 32'(rep_log[q0 + 1]), 32'h3);
    check("sim_p2", 32'(rep_log[q0 + 2]), 32'h5);
    step(40);
    check("sim_pulses_after", 32'(rep_n - q0), 32'h3);
    check("sim_rel_rep", 32'(rel_rep - r0), 32'h0);

    // Reset while key 3 is in auto-repeat
    resetn = 1'b0;
    step(2);
    resetn = 1'b1;
    k = 0;
    mk = 3;
    q0 = rep_n;
    step(1);
    key_n[3] = 1'b0;
    step(64);
    check("mrr_in_repeat", 32'(rep_n - q0), 32'h3);
    resetn = 1'b0;
    #1;
    check("mrr_clean_rst", 32'(key_n_clean[3]), 32'h1);
    check("mrr_repeat_rst", 32'(key_repeat), 32'h0);
    check("mrr_press_rst", 32'(key_press), 32'h0);
    step(3);
    check("mrr_clean_hold", 32'(key_n_clean[3]), 32'h1);
    resetn = 1'b1;
    k = 0;
    p0 = press_cnt;
    while (k < 40 && !key_press[3]) step(1);
    check("mrr_press_k", 32'(k), 32'd13);
    check("mrr_clean_fell", 32'(key_n_clean[3]), 32'h0);
    step(2);
    check("mrr_press_count", 32'(press_cnt - p0), 32'h1);
    key_n[3] = 1'b1;
    step(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_input_conditioner.md
# control_input_conditioner

Front-end conditioner for the scope's front-panel controls. It synchronises and debounces the four raw active-low KEYs and ten slide switches, then produces clean levels, press and auto-repeat strobes, and the slow ~93 Hz control clock. Its outputs feed the controls block directly: clean KEY levels drive the butt0–3 inputs, clean switches drive switch0–9, and `button_clock` drives `buttonClock`.

## Interface
- `DB_CYCLES`, 500000: clock cycles between debounce samples (10 ms at 50 MHz); must be ≥2.
- `TICK_DIV`, 537634: clock cycles per control tick (≈93 Hz at 50 MHz); must be ≥2.
- `REPEAT_DELAY`, 40: control ticks from press to the first auto-repeat; must be ≥1.
- `REPEAT_RATE`, 4: control ticks between subsequent auto-repeats; must be ≥1.

Ports:
- `clock`  in  1  system clock, 50 MHz.
- `resetn`  in  1  asynchronous, active-low reset.
- `key_n`  in  4  raw KEY[3:0], active-low, asynchronous to `clock`.
- `sw`  in  10  raw SW[9:0], asynchronous to `clock`.
- `key_n_clean`  out  4  debounced KEY levels, still active-low.
- `sw_clean`  out  10  debounced switch levels.
- `key_press`  out  4  one-cycle pulse per debounced press (1→0 edge of `key_n_clean`).
- `key_repeat`  out  4  one-cycle pulse on press, then on auto-repeat while held.
- `button_tick`  out  1  one-cycle strobe every `TICK_DIV` cycles.
- `button_clock`  out  1  square wave at the tick rate, high for the first `TICK_DIV/2` counts of each period.

## Operation
- Synchroniser: two flops per input bit (14 bits total). The key stages reset to 1 and the switch stages reset to 0.
- Sample divider: counter `sc` runs 0..DB_CYCLES-1 and wraps. `sample_stb` asserts when `sc == DB_CYCLES-1`.
- Debounce: each input has a 2-bit history `h`. On `sample_stb`, if `h[1] == h[0] == sync`, the clean output takes `sync`. `h` then shifts: `h <= {h[0], sync}`. A level therefore needs 3 consecutive agreeing samples to be accepted. Any shorter excursion is discarded.
- Tick divider: counter `tc` runs 0..TICK_DIV-1 and wraps.
  - `button_tick = (tc == TICK_DIV-1)`, registered.
  - `button_clock = (tc < TICK_DIV/2)`, registered. Integer division applies.
- Press detect: keep the previous value of `key_n_clean`. `key_press[i]` = previous value 1 and current value 0.
- Auto-repeat: one FSM per key, with its own counter of width `$clog2(max(REPEAT_DELAY, REPEAT_RATE)+1)`.
  - IDLE: when `key_press[i]` fires, pulse `key_repeat[i]`, go to DELAY, set cnt=0.
  - DELAY: on each `button_tick`, cnt++. The tick that makes cnt reach REPEAT_DELAY pulses `key_repeat[i]`, goes to REPEAT and clears cnt.
  - REPEAT: on each `button_tick`, cnt++. The tick that makes cnt reach REPEAT_RATE pulses `key_repeat[i]` and clears cnt.
  - Release: `key_n_clean[i]` returning to 1 forces IDLE from any state, with no pulse.
  - Release and `button_tick` in the same cycle: release wins and no pulse is produced.
- Keys are independent. Simultaneous presses give simultaneous pulses.
- Switches have no edge or repeat logic.

## Timing
- Reset values (while `resetn` is low, applied asynchronously):
  - `key_n_clean = 4'hF`, `sw_clean = 0`.
  - `key_press = 0`, `key_repeat = 0`, `button_tick = 0`, `button_clock = 1`.
  - `sc = tc = 0`. All FSMs in IDLE. Histories: keys `2'b11`, switches `2'b00`.
- Reset deassertion: counters start from 0. The first `button_tick` asserts `TICK_DIV` cycles after the first active edge.
- Debounce latency (raw input stable to clean change): 2 cycles of synchroniser, then the 3rd `sample_stb`. This is 2+2·DB_CYCLES+1 to 2+3·DB_CYCLES cycles, depending on phase.
- `key_press`: 1 cycle after the `key_n_clean` edge. The first `key_repeat` pulse is in the same cycle as `key_press`.
- Auto-repeat timing is counted in `button_tick` events, not in clock cycles.
- `button_tick` period: exactly `TICK_DIV` cycles, duty 1/TICK_DIV.
- Reset mid-hold (including in REPEAT): all outputs return to reset values at once. If the key is still held afterwards, it is re-debounced and produces a fresh `key_press`.

## Test plan
Directed scenarios use `DB_CYCLES=4`, `TICK_DIV=10`, `REPEAT_DELAY=3`, `REPEAT_RATE=2`.
- Reset: assert `resetn` low mid-clock → all outputs at their reset values before the next edge. Release → `button_tick` at cycle 10, 20, 30; `button_clock` high for 5 cycles, low for 5.
- Bounce: toggle `key_n[0]` every 3 cycles for 30 cycles, then hold at 0 → `key_n_clean[0]` falls exactly once, within 14 cycles of the last toggle. Exactly one `key_press[0]` pulse.
- Glitch reject: pulse `sw[5]` high for 6 cycles → `sw_clean[5]` stays 0. Hold it high for 20 cycles → `sw_clean[5]` becomes 1.
- Auto-repeat: hold `key_n[1]` low for 120 cycles → `key_repeat[1]` pulses at press, at the 3rd tick after press, then every 2nd tick. Release → no pulse after `key_n_clean[1]` rises.
- Simultaneous events: release `key_n[2]` so that `key_n_clean[2]` rises in the same cycle as a repeat-due `button_tick` → no pulse, FSM in IDLE.
- Reset mid-repeat: drop `resetn` for 3 cycles while `key_n[3]` is held in REPEAT → `key_n_clean[3]=1` during reset. Afterwards `key_n_clean[3]` falls again and a fresh `key_press[3]` appears.
